// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//   On-chip data RAM that answers the EXE-stage data_sram_* request port.
//   It accepts one request per cycle and never stalls. Writes are byte-masked
//   word writes. Reads return after RD_LATENCY cycles, marked by a
//   one-cycle rdata_valid pulse.
//
//   Handshake: data_sram_en is a valid with an implicit ready that is always
//   high, so every cycle with en=1 is an accepted request. On the return
//   side, rdata_valid is a valid with no ready. The consumer must take
//   data_sram_rdata in the cycle that rdata_valid is 1.
//
// Parameters
//   DEPTH_LOG2  log2 of the word count (storage is 2**DEPTH_LOG2 x 32b)
//   RD_LATENCY  read latency in cycles, legal range 1..4
//
// Build option
//   DSRAM_PERF_CNT_EN  when defined, adds the saturating read and write
//                      counters. When undefined, rd_cnt and wr_cnt read 0.
//
// Ports
//   clk              rising-edge clock
//   resetn           asynchronous reset, active low
//   data_sram_en     request valid this cycle
//   data_sram_we     byte-lane write mask; 0 means read
//   data_sram_addr   byte address (word index = addr[DEPTH_LOG2+1:2])
//   data_sram_wdata  write data, lane i = bits [8i+7:8i]
//   data_sram_rdata  read data; holds its value between pulses
//   rdata_valid      one-cycle pulse when a read result retires
//   addr_err         sticky flag, set by any misaligned request
//   rd_cnt           accepted-read counter
//   wr_cnt           accepted-write counter
// ---------------------------------------------------------------------------
module data_sram_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        addr_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  localparam int LAST = RD_LATENCY - 1;

  // Storage has no reset, so its contents survive resetn.
  logic [31:0] mem [2**DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  aligned;
  logic                  rd_req;
  logic                  wr_req;
  logic                  wr_acc;

  // Address bits above the index are ignored, so addresses alias modulo depth.
  logic                  unused_addr_hi;
  assign unused_addr_hi = ^data_sram_addr[31:DEPTH_LOG2+2];

  assign idx     = data_sram_addr[DEPTH_LOG2+1:2];
  assign aligned = (data_sram_addr[1:0] == 2'b00);
  assign rd_req  = data_sram_en && (data_sram_we == 4'h0);
  assign wr_req  = data_sram_en && (data_sram_we != 4'h0);
  assign wr_acc  = wr_req && aligned;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Read pipeline. Stage 0 captures the array at the request edge, and the
  // last stage drives the outputs directly. The total is therefore exactly
  // RD_LATENCY register stages. A stage reloads its data only when a valid
  // result enters it, so the last stage (rdata) holds between pulses.
  // A misaligned read still travels the pipeline, carrying zero data.
  logic [RD_LATENCY-1:0] pipe_v;
  logic [31:0]           pipe_d [RD_LATENCY];
  logic [RD_LATENCY-1:0] in_v;
  logic [31:0]           in_d   [RD_LATENCY];

  always_comb begin
    in_v    = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_d[i] = 32'h0;
    in_v[0] = rd_req;
    in_d[0] = aligned ? mem[idx] : 32'h0;
    for (int i = 1; i < RD_LATENCY; i++) begin
      in_v[i] = pipe_v[i-1];
      in_d[i] = pipe_d[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_d[i] <= 32'h0;
    end else begin
      pipe_v <= in_v;
      for (int i = 0; i < RD_LATENCY; i++) begin
        if (in_v[i]) pipe_d[i] <= in_d[i];
      end
    end
  end

  assign data_sram_rdata = pipe_d[LAST];
  assign rdata_valid     = pipe_v[LAST];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        addr_err <= 1'b0;
    else if (data_sram_en && !aligned)  addr_err <= 1'b1;
  end

`ifdef DSRAM_PERF_CNT_EN
  // Misaligned requests count as accepted. Both counters stop at all-ones.
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      if (rd_req && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_req && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`else
  assign rd_cnt = 32'h0;
  assign wr_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_data_sram_responder
//   Directed, table-driven bench for data_sram_responder with RD_LATENCY=3.
//   Read results are checked by a scoreboard. Each read pushes its expected
//   data and the cycle it must retire. A negedge monitor pops those entries
//   and compares them, and it flags any pulse nobody asked for.
// ---------------------------------------------------------------------------
module tb_data_sram_responder;

  localparam int LAT = 3;
`ifdef DSRAM_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        rdata_valid;
  logic        addr_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  data_sram_responder #(.DEPTH_LOG2(12), .RD_LATENCY(LAT)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .rdata_valid     (rdata_valid),
    .addr_err        (addr_err),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;
  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (resetn && rdata_valid) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'h0, rdata_valid}, 32'h0);
      end else begin
        check("rdata", data_sram_rdata, exp_q.pop_front());
        check("rdata_cycle", cycle_cnt, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp, input bit track);
    @(posedge clk); #1;
    data_sram_en    = en;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    if (track && en && we == 4'h0) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cycle_cnt + LAT);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wdata);
    drive(1'b1, we, addr, wdata, 32'h0, 1'b1);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    drive(1'b1, 4'h0, addr, 32'h0, exp, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic drain(input string name);
    idle(LAT + 2);
    check(name, exp_q.size(), 32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [3:0]  we;    // 0 = read
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // expected read data (reads only)
  } vec_t;

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{4'hF, 32'h10,   32'h1234_5678, 32'h0};
    vecs[1]  = '{4'h0, 32'h10,   32'h0,         32'h1234_5678};
    vecs[2]  = '{4'hF, 32'h20,   32'hAABB_CCDD, 32'h0};
    vecs[3]  = '{4'h5, 32'h20,   32'h1122_3344, 32'h0};
    vecs[4]  = '{4'h0, 32'h20,   32'h0,         32'hAA22_CC44};
    vecs[5]  = '{4'hF, 32'h0,    32'hDEAD_BEEF, 32'h0};
    vecs[6]  = '{4'hF, 32'h4,    32'h0102_0304, 32'h0};
    vecs[7]  = '{4'hF, 32'h8,    32'hCAFE_F00D, 32'h0};
    vecs[8]  = '{4'h0, 32'h0,    32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{4'h0, 32'h4,    32'h0,         32'h0102_0304};
    vecs[10] = '{4'h0, 32'h8,    32'h0,         32'hCAFE_F00D};
    vecs[11] = '{4'hA, 32'h8,    32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{4'h0, 32'h8,    32'h0,         32'hFFFE_FF0D};
    vecs[13] = '{4'hF, 32'h4030, 32'h5A5A_5A5A, 32'h0};
    vecs[14] = '{4'h0, 32'h30,   32'h0,         32'h5A5A_5A5A};
    vecs[15] = '{4'h0, 32'h10,   32'h0,         32'h1234_5678};

    data_sram_en = 1'b0; data_sram_we = 4'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0;

    // Reset values
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_valid", {31'h0, rdata_valid}, 32'h0);
    check("rst_addr_err", {31'h0, addr_err}, 32'h0);
    check("rst_rd_cnt", rd_cnt, 32'h0);
    check("rst_wr_cnt", wr_cnt, 32'h0);
    resetn = 1'b1;
    idle(2);

    // Back-to-back table, no idle cycles between entries
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we == 4'h0) rd(vecs[i].addr, vecs[i].exp);
      else wr(vecs[i].addr, vecs[i].we, vecs[i].wdata);
    end
    drain("table_drain");
    check("hold_rdata", data_sram_rdata, 32'h1234_5678);
    check("idle_valid", {31'h0, rdata_valid}, 32'h0);
    check("table_addr_err", {31'h0, addr_err}, 32'h0);
    check("table_rd_cnt", rd_cnt, PERF ? 32'd8 : 32'd0);
    check("table_wr_cnt", wr_cnt, PERF ? 32'd8 : 32'd0);

    // Misaligned read and write
    rd(32'h6, 32'h0);
    wr(32'h5, 4'hF, 32'hFFFF_FFFF);
    rd(32'h4, 32'h0102_0304);
    drain("misalign_drain");
    check("addr_err_set", {31'h0, addr_err}, 32'h1);
    idle(3);
    check("addr_err_sticky", {31'h0, addr_err}, 32'h1);
    check("mis_rd_cnt", rd_cnt, PERF ? 32'd10 : 32'd0);
    check("mis_wr_cnt", wr_cnt, PERF ? 32'd9 : 32'd0);

    // A read in flight when reset hits is discarded
    drive(1'b1, 4'h0, 32'h10, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    data_sram_en = 1'b0;
    resetn = 1'b0;
    #1;
    check("async_rst_addr_err", {31'h0, addr_err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    begin
      int p0;
      p0 = pulse_cnt;
      idle(LAT + 3);
      check("no_pulse_after_rst", pulse_cnt, p0);
    end
    check("post_rst_rdata", data_sram_rdata, 32'h0);
    check("post_rst_rd_cnt", rd_cnt, 32'h0);
    check("post_rst_wr_cnt", wr_cnt, 32'h0);

    // en=0 with a write mask must do nothing; memory survives reset
    drive(1'b0, 4'hF, 32'h10, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 4'hF, 32'h20, 32'h0, 32'h0, 1'b0);
    rd(32'h10, 32'h1234_5678);
    rd(32'h20, 32'hAA22_CC44);
    wr(32'h40, 4'hF, 32'h0000_0077);
    wr(32'h44, 4'hF, 32'h0000_BEEF);
    wr(32'h48, 4'hF, 32'h0000_0001);
    rd(32'h40, 32'h0000_0077);
    rd(32'h44, 32'h0000_BEEF);
    rd(32'h48, 32'h0000_0001);
    drain("final_drain");
    check("final_rd_cnt", rd_cnt, PERF ? 32'd5 : 32'd0);
    check("final_wr_cnt", wr_cnt, PERF ? 32'd3 : 32'd0);
    check("final_addr_err", {31'h0, addr_err}, 32'h0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
